game_sequencer: RTL and testbench

Top-level game-flow controller for the scrolling-bar game. It sequences play through idle, ready, play, hit and game-over phases, and gates scroll/player motion. It keeps the lives and score counters and arbitrates one-shot sound requests onto the shared `Audio` select lines. It sits between the PS/2 and button inputs, the clock-divider tick, and the `Scrolls`, `PlayerObject` and `Audio` blocks.

---
 rtl/game_sequencer_if.sv | 44 ++++
 rtl/game_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - control and status bundle between the game sequencer and its neighbours
//
// Purpose: groups the sequencer's input events and its registered outputs into one interface.
// Modports:
//   master : drives tick/start_btn/dEnable/collision/goal and observes the outputs.
//   slave  : the sequencer side; it consumes the events and drives the outputs.
// Signals:
//   tick       counted-time pulse from the button clock divider
//   start_btn  start request, synchronous to clk
//   dEnable    run enable (0 pauses the game)
//   collision  player/bar overlap, level
//   goal       player reached goal row, one-cycle pulse
//   state      IDLE=0 READY=1 PLAY=2 HIT=3 OVER=4
//   motion_en  scroll/player movement enable
//   player_rst one-cycle player position reset
//   lives      remaining lives
//   score      goals scored, saturating
//   snd_sel    sound code to Audio (0 none, 1 start, 2 goal, 3 hit, 4 over)
//   snd_en     audio enable

interface game_sequencer_if;
    logic       tick;
    logic       start_btn;
    logic       dEnable;
    logic       collision;
    logic       goal;
    logic [2:0] state;
    logic       motion_en;
    logic       player_rst;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] snd_sel;
    logic       snd_en;

    modport master (
        output tick, start_btn, dEnable, collision, goal,
        input  state, motion_en, player_rst, lives, score, snd_sel, snd_en
    );

    modport slave (
        input  tick, start_btn, dEnable, collision, goal,
        output state, motion_en, player_rst, lives, score, snd_sel, snd_en
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game-flow FSM with lives/score counters and one-shot sound arbiter
//
// Purpose: sequences IDLE -> READY -> PLAY -> HIT -> (READY | OVER), gates scroll and
// player motion, keeps lives and score, and drives the shared Audio select lines.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  game_sequencer_if.slave (events in, registered status/sound out)
// Parameters:
//   LIVES        lives loaded at game start (1..3)
//   READY_TICKS  counted ticks spent in READY
//   HIT_TICKS    counted ticks spent in HIT
//   SND_TICKS    counted ticks a sound request keeps snd_en high

module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int READY_TICKS = 120,
    parameter int HIT_TICKS   = 60,
    parameter int SND_TICKS   = 15
) (
    input  logic          clk,
    input  logic          rst,
    game_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [2:0] SND_NONE  = 3'd0;
    localparam logic [2:0] SND_START = 3'd1;
    localparam logic [2:0] SND_GOAL  = 3'd2;
    localparam logic [2:0] SND_HIT   = 3'd3;
    localparam logic [2:0] SND_OVER  = 3'd4;

    // One phase counter serves both READY and HIT; size it for the longer phase.
    localparam int PMAX = (READY_TICKS > HIT_TICKS) ? READY_TICKS : HIT_TICKS;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int SW   = $clog2(SND_TICKS + 1);

    state_t          state_q;
    logic [PW-1:0]   phase_cnt;
    logic [SW-1:0]   snd_cnt;
    logic [1:0]      lives_q;
    logic [7:0]      score_q;
    logic            motion_en_q;
    logic            player_rst_q;
    logic [2:0]      snd_sel_q;
    logic            snd_en_q;
    logic            start_q;
    logic            start_armed;

    logic            ctick;
    logic            start_edge;
    logic            ready_done;
    logic            hit_done;
    logic            snd_req;
    logic [2:0]      snd_code;

    // start_armed stays low until start_btn has been seen low after reset, so a
    // button held through reset cannot fake an edge when start_q comes out at 0.
    assign ctick      = bus.tick & bus.dEnable;
    assign start_edge = bus.start_btn & ~start_q & start_armed;
    assign ready_done = ctick && (phase_cnt == PW'(READY_TICKS - 1));
    assign hit_done   = ctick && (phase_cnt == PW'(HIT_TICKS - 1));

    // Sound requests mirror the FSM transitions that trigger them.
    always_comb begin
        snd_req  = 1'b0;
        snd_code = SND_NONE;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    snd_req  = 1'b1;
                    snd_code = SND_START;
                end
            end
            ST_PLAY: begin
                if (bus.collision) begin
                    snd_req  = 1'b1;
                    snd_code = SND_HIT;
                end else if (bus.goal) begin
                    snd_req  = 1'b1;
                    snd_code = SND_GOAL;
                end
            end
            ST_HIT: begin
                if (hit_done && (lives_q == 2'd0)) begin
                    snd_req  = 1'b1;
                    snd_code = SND_OVER;
                end
            end
            default: begin
                snd_req  = 1'b0;
                snd_code = SND_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_q <= bus.start_btn;
            if (!bus.start_btn) begin
                start_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_cnt    <= '0;
            lives_q      <= 2'd0;
            score_q      <= 8'd0;
            motion_en_q  <= 1'b0;
            player_rst_q <= 1'b0;
        end else begin
            player_rst_q <= 1'b0;
            motion_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_edge) begin
                        state_q      <= ST_READY;
                        phase_cnt    <= '0;
                        lives_q      <= 2'(LIVES);
                        score_q      <= 8'd0;
                        player_rst_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (ready_done) begin
                        state_q     <= ST_PLAY;
                        phase_cnt   <= '0;
                        // ready_done implies dEnable=1, so motion starts with PLAY.
                        motion_en_q <= 1'b1;
                    end else if (ctick) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (bus.collision) begin
                        state_q   <= ST_HIT;
                        phase_cnt <= '0;
                        if (lives_q != 2'd0) begin
                            lives_q <= lives_q - 2'd1;
                        end
                    end else begin
                        motion_en_q <= bus.dEnable;
                        if (bus.goal) begin
                            player_rst_q <= 1'b1;
                            if (score_q != 8'hFF) begin
                                score_q <= score_q + 8'd1;
                            end
                        end
                    end
                end
                ST_HIT: begin
                    if (hit_done) begin
                        phase_cnt <= '0;
                        if (lives_q == 2'd0) begin
                            state_q <= ST_OVER;
                        end else begin
                            state_q      <= ST_READY;
                            player_rst_q <= 1'b1;
                        end
                    end else if (ctick) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

    // A new request always wins over a sound in progress and restarts its duration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_sel_q <= SND_NONE;
            snd_en_q  <= 1'b0;
            snd_cnt   <= '0;
        end else if (snd_req) begin
            snd_sel_q <= snd_code;
            snd_en_q  <= 1'b1;
            snd_cnt   <= '0;
        end else if (snd_en_q && ctick) begin
            if (snd_cnt == SW'(SND_TICKS - 1)) begin
                snd_sel_q <= SND_NONE;
                snd_en_q  <= 1'b0;
                snd_cnt   <= '0;
            end else begin
                snd_cnt <= snd_cnt + 1'b1;
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.motion_en  = motion_en_q;
    assign bus.player_rst = player_rst_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.snd_sel    = snd_sel_q;
    assign bus.snd_en     = snd_en_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer

module tb_game_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    game_sequencer_if bus();

    game_sequencer #(
        .LIVES      (2),
        .READY_TICKS(2),
        .HIT_TICKS  (3),
        .SND_TICKS  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick every 4 cycles; returns just after the edge that sampled the tick.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) step();
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.tick      = 1'b0;
        bus.start_btn = 1'b1;
        bus.dEnable   = 1'b1;
        bus.collision = 1'b0;
        bus.goal      = 1'b0;

        step();
        step();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_lives", 32'(bus.lives), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_motion", 32'(bus.motion_en), 0);
        chk("rst_prst", 32'(bus.player_rst), 0);
        chk("rst_snd_sel", 32'(bus.snd_sel), 0);
        chk("rst_snd_en", 32'(bus.snd_en), 0);

        // start_btn held high through reset release: no start
        rst = 1'b0;
        repeat (3) step();
        chk("held_start_state", 32'(bus.state), 0);
        bus.start_btn = 1'b0;
        step();
        chk("btn_low_state", 32'(bus.state), 0);
        bus.start_btn = 1'b1;
        step();
        chk("start_state", 32'(bus.state), 1);
        chk("start_lives", 32'(bus.lives), 2);
        chk("start_score", 32'(bus.score), 0);
        chk("start_prst", 32'(bus.player_rst), 1);
        chk("start_snd_sel", 32'(bus.snd_sel), 1);
        chk("start_snd_en", 32'(bus.snd_en), 1);
        chk("start_motion", 32'(bus.motion_en), 0);
        bus.start_btn = 1'b0;
        step();
        chk("start_prst_drop", 32'(bus.player_rst), 0);

        tick_n(1);
        chk("ready_t1_state", 32'(bus.state), 1);
        chk("ready_t1_snd_en", 32'(bus.snd_en), 1);
        tick_n(1);
        chk("play_state", 32'(bus.state), 2);
        chk("play_motion", 32'(bus.motion_en), 1);
        chk("start_snd_end_en", 32'(bus.snd_en), 0);
        chk("start_snd_end_sel", 32'(bus.snd_sel), 0);

        // motion_en follows dEnable in PLAY
        bus.dEnable = 1'b0;
        step();
        chk("play_pause_motion", 32'(bus.motion_en), 0);
        chk("play_pause_state", 32'(bus.state), 2);
        bus.dEnable = 1'b1;
        step();
        chk("play_resume_motion", 32'(bus.motion_en), 1);

        // goal then preempting goal
        bus.goal = 1'b1;
        step();
        bus.goal = 1'b0;
        chk("goal1_score", 32'(bus.score), 1);
        chk("goal1_prst", 32'(bus.player_rst), 1);
        chk("goal1_snd_sel", 32'(bus.snd_sel), 2);
        chk("goal1_snd_en", 32'(bus.snd_en), 1);
        step();
        chk("goal1_prst_drop", 32'(bus.player_rst), 0);
        tick_n(1);
        bus.goal = 1'b1;
        step();
        bus.goal = 1'b0;
        chk("goal2_score", 32'(bus.score), 2);
        chk("goal2_snd_sel", 32'(bus.snd_sel), 2);
        tick_n(1);
        chk("preempt_t1_snd_en", 32'(bus.snd_en), 1);
        chk("preempt_t1_snd_sel", 32'(bus.snd_sel), 2);
        tick_n(1);
        chk("preempt_t2_snd_en", 32'(bus.snd_en), 0);
        chk("preempt_t2_snd_sel", 32'(bus.snd_sel), 0);

        // saturate score
        for (int i = 0; i < 253; i++) begin
            bus.goal = 1'b1;
            step();
            bus.goal = 1'b0;
            step();
        end
        chk("score_255", 32'(bus.score), 255);
        bus.goal = 1'b1;
        step();
        bus.goal = 1'b0;
        chk("sat_score", 32'(bus.score), 255);
        chk("sat_prst", 32'(bus.player_rst), 1);
        chk("sat_snd_sel", 32'(bus.snd_sel), 2);

        // collision and goal together: collision wins
        bus.collision = 1'b1;
        bus.goal      = 1'b1;
        step();
        bus.collision = 1'b0;
        bus.goal      = 1'b0;
        chk("hit1_state", 32'(bus.state), 3);
        chk("hit1_lives", 32'(bus.lives), 1);
        chk("hit1_score", 32'(bus.score), 255);
        chk("hit1_snd_sel", 32'(bus.snd_sel), 3);
        chk("hit1_prst", 32'(bus.player_rst), 0);
        chk("hit1_motion", 32'(bus.motion_en), 0);
        tick_n(2);
        chk("hit1_t2_state", 32'(bus.state), 3);
        tick_n(1);
        chk("hit1_exit_state", 32'(bus.state), 1);
        chk("hit1_exit_prst", 32'(bus.player_rst), 1);
        tick_n(2);
        chk("play2_state", 32'(bus.state), 2);

        bus.collision = 1'b1;
        step();
        bus.collision = 1'b0;
        chk("hit2_state", 32'(bus.state), 3);
        chk("hit2_lives", 32'(bus.lives), 0);
        tick_n(3);
        chk("over_state", 32'(bus.state), 4);
        chk("over_lives", 32'(bus.lives), 0);
        chk("over_snd_sel", 32'(bus.snd_sel), 4);
        chk("over_snd_en", 32'(bus.snd_en), 1);
        chk("over_motion", 32'(bus.motion_en), 0);

        // restart from OVER
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        chk("restart_state", 32'(bus.state), 1);
        chk("restart_lives", 32'(bus.lives), 2);
        chk("restart_score", 32'(bus.score), 0);
        chk("restart_snd_sel", 32'(bus.snd_sel), 1);

        // start edges ignored outside IDLE/OVER
        step();
        bus.start_btn = 1'b1;
        step();
        bus.start_btn = 1'b0;
        chk("ready_start_ignored_prst", 32'(bus.player_rst), 0);

        // pause in READY
        bus.dEnable = 1'b0;
        tick_n(10);
        chk("pause_state", 32'(bus.state), 1);
        chk("pause_motion", 32'(bus.motion_en), 0);
        chk("pause_snd_en", 32'(bus.snd_en), 1);
        bus.dEnable = 1'b1;
        tick_n(1);
        chk("resume_t1_state", 32'(bus.state), 1);
        tick_n(1);
        chk("resume_t2_state", 32'(bus.state), 2);

        // asynchronous reset while in HIT with a sound playing
        bus.collision = 1'b1;
        step();
        bus.collision = 1'b0;
        tick_n(1);
        chk("pre_rst_state", 32'(bus.state), 3);
        chk("pre_rst_snd_en", 32'(bus.snd_en), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state), 0);
        chk("async_rst_lives", 32'(bus.lives), 0);
        chk("async_rst_snd_en", 32'(bus.snd_en), 0);
        chk("async_rst_snd_sel", 32'(bus.snd_sel), 0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
